// File: rtl/reg_file.sv
// reg_file: physical register file behind the scoreboard's sb2rf interfaces.
// Each FU has one registered two-operand read channel with valid/ready
// back-pressure and one write request channel. A round-robin arbiter grants
// at most NUM_WR_PORT writes per cycle. Register 0 always reads as zero.
module reg_file #(
    parameter int NUM_REG     = 8,
    parameter int NUM_FU      = 4,
    parameter int REG_BIT     = 16,
    parameter int NUM_WR_PORT = 2,
    parameter int REG_ID_BIT  = $clog2(NUM_REG),
    parameter int FU_ID_BIT   = $clog2(NUM_FU)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_FU-1:0]            sb2rf_read_reg_id_vld,
    output logic [NUM_FU-1:0]            sb2rf_read_reg_id_rdy,
    input  logic [NUM_FU*REG_ID_BIT-1:0] sb2rf_read_reg0_id,
    input  logic [NUM_FU*REG_ID_BIT-1:0] sb2rf_read_reg1_id,
    output logic [NUM_FU-1:0]            rf2fu_read_data_vld,
    input  logic [NUM_FU-1:0]            rf2fu_read_data_rdy,
    output logic [NUM_FU*REG_BIT-1:0]    rf2fu_read_data0,
    output logic [NUM_FU*REG_BIT-1:0]    rf2fu_read_data1,
    input  logic [NUM_FU-1:0]            sb2rf_write_reg_id_vld,
    output logic [NUM_FU-1:0]            sb2rf_write_reg_id_rdy,
    input  logic [NUM_FU*REG_ID_BIT-1:0] sb2rf_write_reg_id,
    input  logic [NUM_FU*REG_BIT-1:0]    sb2rf_write_data
);

    logic [REG_BIT-1:0]        mem_q [NUM_REG];
    logic [REG_BIT-1:0]        mem_d [NUM_REG];
    logic [NUM_FU-1:0]         rsp_vld_q;
    logic [NUM_FU-1:0]         rsp_vld_d;
    logic [NUM_FU*REG_BIT-1:0] rsp_data0_q;
    logic [NUM_FU*REG_BIT-1:0] rsp_data0_d;
    logic [NUM_FU*REG_BIT-1:0] rsp_data1_q;
    logic [NUM_FU*REG_BIT-1:0] rsp_data1_d;
    logic [FU_ID_BIT-1:0]      wr_ptr_q;
    logic [FU_ID_BIT-1:0]      wr_ptr_d;
    logic [NUM_FU-1:0]         wr_gnt;
    logic [NUM_FU-1:0]         rd_accept;

    // Index 0 is the "no register" id; ids beyond NUM_REG do not exist.
    function automatic logic id_in_range(input logic [REG_ID_BIT-1:0] id);
        return (id != '0) && (int'(id) < NUM_REG);
    endfunction

    assign sb2rf_read_reg_id_rdy  = ~rsp_vld_q | rf2fu_read_data_rdy;
    assign rd_accept              = sb2rf_read_reg_id_vld & sb2rf_read_reg_id_rdy;
    assign rf2fu_read_data_vld    = rsp_vld_q;
    assign rf2fu_read_data0       = rsp_data0_q;
    assign rf2fu_read_data1       = rsp_data1_q;
    assign sb2rf_write_reg_id_rdy = wr_gnt;

    // Read response stage: capture pre-write array contents on accept, drop valid once consumed.
    always_comb begin
        logic [REG_ID_BIT-1:0] id0;
        logic [REG_ID_BIT-1:0] id1;
        id0         = '0;
        id1         = '0;
        rsp_vld_d   = rsp_vld_q;
        rsp_data0_d = rsp_data0_q;
        rsp_data1_d = rsp_data1_q;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            id0 = sb2rf_read_reg0_id[i*REG_ID_BIT +: REG_ID_BIT];
            id1 = sb2rf_read_reg1_id[i*REG_ID_BIT +: REG_ID_BIT];
            if (rd_accept[i]) begin
                rsp_vld_d[i] = 1'b1;
                rsp_data0_d[i*REG_BIT +: REG_BIT] = id_in_range(id0) ? mem_q[id0] : '0;
                rsp_data1_d[i*REG_BIT +: REG_BIT] = id_in_range(id1) ? mem_q[id1] : '0;
            end else if (rf2fu_read_data_rdy[i]) begin
                rsp_vld_d[i] = 1'b0;
            end
        end
    end

    // Write arbitration: scan FUs from wr_ptr, grant the first NUM_WR_PORT requesters
    // and apply their writes in scan order so a later grant to the same index wins.
    always_comb begin
        logic [FU_ID_BIT-1:0]  fu;
        logic [REG_ID_BIT-1:0] wid;
        int unsigned           n_gnt;
        fu       = '0;
        wid      = '0;
        n_gnt    = 0;
        wr_gnt   = '0;
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            fu = FU_ID_BIT'((int'(wr_ptr_q) + k) % NUM_FU);
            if (sb2rf_write_reg_id_vld[fu] && (n_gnt < NUM_WR_PORT)) begin
                wr_gnt[fu] = 1'b1;
                n_gnt      = n_gnt + 1;
                wr_ptr_d   = FU_ID_BIT'((int'(fu) + 1) % NUM_FU);
                wid        = sb2rf_write_reg_id[fu*REG_ID_BIT +: REG_ID_BIT];
                if (id_in_range(wid)) begin
                    mem_d[wid] = sb2rf_write_data[fu*REG_BIT +: REG_BIT];
                end
            end
        end
    end

    // State registers: array, response stages and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_REG; r++) begin
                mem_q[r] <= '0;
            end
            rsp_vld_q   <= '0;
            rsp_data0_q <= '0;
            rsp_data1_q <= '0;
            wr_ptr_q    <= '0;
        end else begin
            mem_q       <= mem_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_data0_q <= rsp_data0_d;
            rsp_data1_q <= rsp_data1_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed plan items followed by randomized traffic, checked every
// cycle against a behavioural register-file model kept in the bench.
module tb_reg_file;

    localparam int NUM_REG     = 8;
    localparam int NUM_FU      = 4;
    localparam int REG_BIT     = 16;
    localparam int NUM_WR_PORT = 2;
    localparam int RB          = 3;
    localparam int GNT_BOUND   = (NUM_FU + NUM_WR_PORT - 1) / NUM_WR_PORT;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_FU-1:0]        rd_vld;
    logic [NUM_FU-1:0]        rd_rdy;
    logic [NUM_FU*RB-1:0]     rd_id0;
    logic [NUM_FU*RB-1:0]     rd_id1;
    logic [NUM_FU-1:0]        rsp_vld;
    logic [NUM_FU-1:0]        rsp_rdy;
    logic [NUM_FU*REG_BIT-1:0] rsp_d0;
    logic [NUM_FU*REG_BIT-1:0] rsp_d1;
    logic [NUM_FU-1:0]        wr_vld;
    logic [NUM_FU-1:0]        wr_rdy;
    logic [NUM_FU*RB-1:0]     wr_id;
    logic [NUM_FU*REG_BIT-1:0] wr_data;

    int tests = 0;
    int fails = 0;

    reg_file #(
        .NUM_REG    (NUM_REG),
        .NUM_FU     (NUM_FU),
        .REG_BIT    (REG_BIT),
        .NUM_WR_PORT(NUM_WR_PORT)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .sb2rf_read_reg_id_vld (rd_vld),
        .sb2rf_read_reg_id_rdy (rd_rdy),
        .sb2rf_read_reg0_id    (rd_id0),
        .sb2rf_read_reg1_id    (rd_id1),
        .rf2fu_read_data_vld   (rsp_vld),
        .rf2fu_read_data_rdy   (rsp_rdy),
        .rf2fu_read_data0      (rsp_d0),
        .rf2fu_read_data1      (rsp_d1),
        .sb2rf_write_reg_id_vld(wr_vld),
        .sb2rf_write_reg_id_rdy(wr_rdy),
        .sb2rf_write_reg_id    (wr_id),
        .sb2rf_write_data      (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [REG_BIT-1:0] d0(input int fu);
        return rsp_d0[fu*REG_BIT +: REG_BIT];
    endfunction

    function automatic logic [REG_BIT-1:0] d1(input int fu);
        return rsp_d1[fu*REG_BIT +: REG_BIT];
    endfunction

    task automatic set_rd(input int fu, input int id0, input int id1);
        rd_id0[fu*RB +: RB] = RB'(id0);
        rd_id1[fu*RB +: RB] = RB'(id1);
    endtask

    task automatic set_wr(input int fu, input int id, input logic [REG_BIT-1:0] data);
        wr_id[fu*RB +: RB]           = RB'(id);
        wr_data[fu*REG_BIT +: REG_BIT] = data;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    logic [REG_BIT-1:0] m_mem [NUM_REG];
    logic [NUM_FU-1:0]  m_vld;
    logic [REG_BIT-1:0] m_d0 [NUM_FU];
    logic [REG_BIT-1:0] m_d1 [NUM_FU];
    int unsigned        m_ptr;
    int unsigned        wait_cnt [NUM_FU];

    function automatic logic [REG_BIT-1:0] m_read(input int unsigned id);
        if (id == 0 || id >= NUM_REG) return '0;
        return m_mem[id];
    endfunction

    // Compare DUT against the model, then advance the model to the state after the next edge.
    always @(negedge clk) begin : cmp
        int unsigned       order [$];
        logic [NUM_FU-1:0] exp_gnt;
        logic [NUM_FU-1:0] exp_rrdy;
        int unsigned       fu;
        int unsigned       id;
        if (!rst_n) begin
            for (int r = 0; r < NUM_REG; r++) m_mem[r] = '0;
            m_vld = '0;
            m_ptr = 0;
            for (int i = 0; i < NUM_FU; i++) begin
                m_d0[i]     = '0;
                m_d1[i]     = '0;
                wait_cnt[i] = 0;
            end
        end else begin
            order.delete();
            for (int k = 0; k < NUM_FU; k++) begin
                fu = (m_ptr + k) % NUM_FU;
                if (wr_vld[fu] && order.size() < NUM_WR_PORT) order.push_back(fu);
            end
            exp_gnt = '0;
            foreach (order[j]) exp_gnt[order[j]] = 1'b1;
            exp_rrdy = ~m_vld | rsp_rdy;

            check("read_req_rdy", rd_rdy, exp_rrdy);
            check("write_grant", wr_rdy, exp_gnt);
            check("rsp_vld", rsp_vld, m_vld);
            for (int i = 0; i < NUM_FU; i++) begin
                check("rsp_data0", d0(i), m_d0[i]);
                check("rsp_data1", d1(i), m_d1[i]);
                if (wr_vld[i]) begin
                    if (wr_rdy[i]) begin
                        check("grant_within_bound", wait_cnt[i] < GNT_BOUND, 1);
                        wait_cnt[i] = 0;
                    end else begin
                        wait_cnt[i]++;
                    end
                end else begin
                    wait_cnt[i] = 0;
                end
            end

            for (int i = 0; i < NUM_FU; i++) begin
                if (rd_vld[i] && exp_rrdy[i]) begin
                    m_vld[i] = 1'b1;
                    m_d0[i]  = m_read(rd_id0[i*RB +: RB]);
                    m_d1[i]  = m_read(rd_id1[i*RB +: RB]);
                end else if (rsp_rdy[i]) begin
                    m_vld[i] = 1'b0;
                end
            end
            foreach (order[j]) begin
                id = wr_id[order[j]*RB +: RB];
                if (id != 0 && id < NUM_REG) m_mem[id] = wr_data[order[j]*REG_BIT +: REG_BIT];
            end
            if (order.size() > 0) m_ptr = (order[order.size()-1] + 1) % NUM_FU;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [NUM_FU-1:0] acc;
        logic [NUM_FU-1:0] gnt;
        rst_n   = 1'b0;
        rd_vld  = '0;
        rsp_rdy = '1;
        wr_vld  = '0;
        rd_id0  = '0;
        rd_id1  = '0;
        wr_id   = '0;
        wr_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check("reset_rsp_vld", rsp_vld, 4'h0);
        check("reset_rd_rdy", rd_rdy, 4'hF);
        check("reset_data0", rsp_d0, 64'h0);
        check("reset_data1", rsp_d1, 64'h0);

        // Read r3/r0 on FU0 right after reset.
        next_cycle();
        set_rd(0, 3, 0);
        rd_vld = 4'b0001;
        @(negedge clk);
        check("all_read_rdy", rd_rdy, 4'hF);
        next_cycle();
        rd_vld = '0;
        @(negedge clk);
        check("first_rsp_vld", rsp_vld[0], 1'b1);
        check("first_rsp_d0", d0(0), 16'h0);
        check("first_rsp_d1", d1(0), 16'h0);

        // Uncontended write then read-back.
        next_cycle();
        set_wr(1, 5, 16'hBEEF);
        wr_vld = 4'b0010;
        @(negedge clk);
        check("lone_write_grant", wr_rdy, 4'b0010);
        next_cycle();
        wr_vld = '0;
        set_rd(2, 5, 0);
        rd_vld = 4'b0100;
        next_cycle();
        rd_vld = '0;
        @(negedge clk);
        check("readback_beef", d0(2), 16'hBEEF);

        // Reset returns wr_ptr to 0 and clears the array; then full contention.
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        set_rd(1, 5, 5);
        rd_vld = 4'b0010;
        for (int k = 0; k < NUM_FU; k++) set_wr(k, k + 1, 16'(16'h1000 + k));
        wr_vld = 4'hF;
        @(negedge clk);
        check("contend_cycle1", wr_rdy, 4'b0011);
        next_cycle();
        rd_vld = '0;
        wr_vld = 4'b1100;
        @(negedge clk);
        check("contend_cycle2", wr_rdy, 4'b1100);
        check("reset_cleared_r5", d0(1), 16'h0);

        // Pointer walk: FU0 alone (ptr->1), FU3 alone (ptr->0), then FU0+FU3.
        next_cycle();
        set_wr(0, 6, 16'h6666);
        wr_vld = 4'b0001;
        @(negedge clk);
        check("ptr_setup_fu0", wr_rdy, 4'b0001);
        next_cycle();
        set_wr(3, 7, 16'h7777);
        wr_vld = 4'b1000;
        @(negedge clk);
        check("fu3_only", wr_rdy, 4'b1000);
        next_cycle();
        set_wr(0, 6, 16'h0606);
        set_wr(3, 7, 16'h0707);
        wr_vld = 4'b1001;
        @(negedge clk);
        check("fu0_and_fu3", wr_rdy, 4'b1001);

        // Same-index writes in one cycle: later in scan order wins (ptr=0 then wrapped ptr=3).
        next_cycle();
        set_wr(1, 3, 16'hAAAA);
        set_wr(2, 3, 16'h5555);
        wr_vld = 4'b0110;
        @(negedge clk);
        check("dup_pair_grant", wr_rdy, 4'b0110);
        next_cycle();
        wr_vld = '0;
        set_rd(0, 3, 6);
        rd_vld = 4'b0001;
        next_cycle();
        rd_vld = '0;
        set_wr(3, 3, 16'h3333);
        set_wr(0, 3, 16'h0303);
        wr_vld = 4'b1001;
        @(negedge clk);
        check("dup_later_wins", d0(0), 16'h5555);
        check("r6_value", d1(0), 16'h0606);
        check("wrap_pair_grant", wr_rdy, 4'b1001);
        next_cycle();
        wr_vld = '0;
        set_rd(0, 3, 7);
        rd_vld = 4'b0001;
        next_cycle();
        rd_vld = '0;
        @(negedge clk);
        check("dup_wrap_later_wins", d0(0), 16'h0303);
        check("r7_value", d1(0), 16'h0707);

        // Back-pressure on FU0 for three cycles, then release with a request pending.
        next_cycle();
        rsp_rdy[0] = 1'b0;
        set_rd(0, 1, 2);
        rd_vld = 4'b0001;
        next_cycle();
        set_rd(0, 3, 4);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("held_vld", rsp_vld[0], 1'b1);
            check("held_req_rdy", rd_rdy[0], 1'b0);
            check("held_d0", d0(0), 16'h1000);
            check("held_d1", d1(0), 16'h1001);
            next_cycle();
        end
        rsp_rdy[0] = 1'b1;
        @(negedge clk);
        check("release_req_rdy", rd_rdy[0], 1'b1);
        check("release_d0", d0(0), 16'h1000);
        next_cycle();
        rd_vld = '0;
        @(negedge clk);
        check("no_bubble_vld", rsp_vld[0], 1'b1);
        check("no_bubble_d0", d0(0), 16'h0303);
        check("no_bubble_d1", d1(0), 16'h1003);

        // No write-to-read bypass, and r0 ignores writes.
        next_cycle();
        set_wr(1, 4, 16'h0022);
        wr_vld = 4'b0010;
        next_cycle();
        set_wr(1, 4, 16'h0011);
        set_rd(2, 4, 4);
        rd_vld = 4'b0100;
        next_cycle();
        rd_vld = '0;
        set_wr(1, 0, 16'hFFFF);
        @(negedge clk);
        check("no_bypass_old_value", d0(2), 16'h0022);
        next_cycle();
        wr_vld = '0;
        set_rd(2, 0, 4);
        rd_vld = 4'b0100;
        next_cycle();
        rd_vld = '0;
        @(negedge clk);
        check("r0_reads_zero", d0(2), 16'h0);
        check("r4_new_value", d1(2), 16'h0011);

        // Randomized traffic; unaccepted requests are held, one mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = rd_vld & rd_rdy;
            gnt = wr_vld & wr_rdy;
            next_cycle();
            if (c == 1500) rst_n = 1'b0;
            if (c == 1502) rst_n = 1'b1;
            for (int i = 0; i < NUM_FU; i++) begin
                if (!(rd_vld[i] && !acc[i])) begin
                    rd_vld[i] = 1'($urandom_range(0, 1));
                    set_rd(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
                end
                rsp_rdy[i] = ($urandom_range(0, 3) != 0);
                if (!(wr_vld[i] && !gnt[i])) begin
                    wr_vld[i] = ($urandom_range(0, 2) != 0);
                    set_wr(i, int'($urandom_range(0, 7)), 16'($urandom));
                end
            end
        end

        rd_vld = '0;
        wr_vld = '0;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
